// File: rtl/cpu_pkg.sv
// Definitions shared by simple_cpu and its program sequencer:
// opcode values, opcode field placement, sequencer states and default cycle counts.
package cpu_pkg;

  // The opcode occupies the top OPC_W bits of every instruction word.
  localparam int OPC_W = 2;

  localparam logic [OPC_W-1:0] OPC_NOP_HALT = 2'b00;
  localparam logic [OPC_W-1:0] OPC_ALU      = 2'b01;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 2'b10;
  localparam logic [OPC_W-1:0] OPC_STORE    = 2'b11;

  localparam int DEF_INSTR_WIDTH    = 20;
  localparam int DEF_PC_BITS        = 5;
  localparam int DEF_ALU_CYCLES     = 3;
  localparam int DEF_LOAD_CYCLES    = 4;
  localparam int DEF_STORE_CYCLES   = 3;
  localparam int DEF_CPU_RST_CYCLES = 2;

  // Wide enough for any hold count up to 16 cycles.
  localparam int HOLD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_RST,
    ST_FETCH,
    ST_ISSUE,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/instr_rom_sp.sv
// Program memory for the sequencer: one synchronous write port and a registered read.
module instr_rom_sp #(
  parameter int ADDR_BITS  = 5,
  parameter int DATA_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_program_sequencer.sv
// Replays a preloaded program into simple_cpu: resets the CPU, then presents each
// instruction for an opcode-dependent number of cycles and pulses done at the end.
module cpu_program_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
  parameter int PC_BITS        = DEF_PC_BITS,
  parameter int ALU_CYCLES     = DEF_ALU_CYCLES,
  parameter int LOAD_CYCLES    = DEF_LOAD_CYCLES,
  parameter int STORE_CYCLES   = DEF_STORE_CYCLES,
  parameter int CPU_RST_CYCLES = DEF_CPU_RST_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic [PC_BITS:0]       prog_len,
  input  logic                   start,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic [PC_BITS-1:0]     pc
);

  localparam int LEN_W = PC_BITS + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**PC_BITS);

  seq_state_e             state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [INSTR_WIDTH-1:0] rom_rdata;
  logic [LEN_W-1:0]       pc_plus_one;

  // Hold counters count down to zero, so they are loaded with N-1.
  function automatic logic [HOLD_W-1:0] hold_for(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_ALU:   return HOLD_W'(ALU_CYCLES - 1);
      OPC_LOAD:  return HOLD_W'(LOAD_CYCLES - 1);
      OPC_STORE: return HOLD_W'(STORE_CYCLES - 1);
      default:   return '0;
    endcase
  endfunction

  // Reading at pc_d makes mem[pc] available during FETCH, ready to register on ISSUE entry.
  instr_rom_sp #(
    .ADDR_BITS  (PC_BITS),
    .DATA_WIDTH (INSTR_WIDTH)
  ) u_rom (
    .clk   (clk),
    .we    (prog_we && !busy_q),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_d),
    .rdata (rom_rdata)
  );

  assign pc_plus_one = LEN_W'(pc_q) + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    len_d   = len_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
          instr_d = '0;
          if (prog_len != '0) begin
            state_d = ST_CPU_RST;
            hold_d  = HOLD_W'(CPU_RST_CYCLES - 1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CPU_RST: begin
        instr_d = '0;
        if (hold_q == '0) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_FETCH: begin
        state_d = ST_ISSUE;
        instr_d = rom_rdata;
        hold_d  = hold_for(rom_rdata[INSTR_WIDTH-1 -: OPC_W]);
      end
      ST_ISSUE: begin
        if (instr_q[INSTR_WIDTH-1 -: OPC_W] == OPC_NOP_HALT) begin
          state_d = ST_DONE;
          instr_d = '0;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (pc_plus_one == len_q) begin
          state_d = ST_DONE;
          instr_d = '0;
        end else begin
          state_d = ST_FETCH;
          pc_d    = pc_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        instr_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        instr_d = '0;
      end
    endcase

    // Abort drops the run without a done pulse and parks pc back at zero.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      instr_d = '0;
      pc_d    = '0;
      hold_d  = '0;
    end

    cpu_rst_d = (state_d == ST_CPU_RST);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pc_q      <= '0;
      hold_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
    end
  end

  assign instruction = instr_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Self-checking bench for cpu_program_sequencer: expected per-cycle outputs are queued
// from the program description and compared on the falling edge.
module tb_cpu_program_sequencer;
  import cpu_pkg::*;

  localparam int IW = 20;
  localparam int PB = 5;
  localparam int RST_CYCLES = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [PB-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [PB:0]   prog_len;
  logic          start;
  logic          abort;
  logic [IW-1:0] instruction;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic [PB-1:0] pc;

  always #5 clk = ~clk;

  cpu_program_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .abort       (abort),
    .instruction (instruction),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .done        (done),
    .pc          (pc)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic          cpuRst;
    logic          busy;
    logic          done;
    logic [PB-1:0] pc;
  } obs_t;

  typedef struct {
    logic [IW-1:0] word;
    int            hold;
    string         label;
  } vec_t;

  obs_t          expQ[$];
  int            passCount = 0;
  int            checkCount = 0;
  logic [IW-1:0] progWords[32];
  int            progHolds[32];
  logic [IW-1:0] fullWords[6];
  int            fullHolds[6];
  logic [PB-1:0] lastPc;
  string         curLabel;
  vec_t          vecs[6];

  function automatic obs_t makeObs(input logic [IW-1:0] i, input logic r, input logic b,
                                   input logic d, input logic [PB-1:0] p);
    obs_t o;
    o.instr = i; o.cpuRst = r; o.busy = b; o.done = d; o.pc = p;
    return o;
  endfunction

  function automatic obs_t sampleDut();
    return makeObs(instruction, cpu_rst, busy, done, pc);
  endfunction

  task automatic checkOutput(input string name, input obs_t actual, input obs_t expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got instr=%h cpu_rst=%b busy=%b done=%b pc=%0d, want instr=%h cpu_rst=%b busy=%b done=%b pc=%0d",
                  name, actual.instr, actual.cpuRst, actual.busy, actual.done, actual.pc,
                  expected.instr, expected.cpuRst, expected.busy, expected.done, expected.pc);
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    @(negedge clk);
    start = s;
    abort = a;
  endtask

  task automatic loadProgram(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = PB'(i); prog_data = progWords[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic useFullProgram();
    for (int i = 0; i < 6; i++) begin
      progWords[i] = fullWords[i];
      progHolds[i] = fullHolds[i];
    end
  endtask

  // Builds the cycle-by-cycle picture of one run; hold 0 marks a HALT word.
  task automatic pushRun(input int len);
    int            eff;
    logic [IW-1:0] prev;
    eff  = (len > 32) ? 32 : len;
    prev = '0;
    if (eff == 0) begin
      expQ.push_back(makeObs('0, 1'b0, 1'b1, 1'b1, lastPc));
      expQ.push_back(makeObs('0, 1'b0, 1'b0, 1'b0, lastPc));
      return;
    end
    repeat (RST_CYCLES) expQ.push_back(makeObs('0, 1'b1, 1'b1, 1'b0, lastPc));
    for (int i = 0; i < eff; i++) begin
      expQ.push_back(makeObs(prev, 1'b0, 1'b1, 1'b0, PB'(i)));
      if (progHolds[i] == 0) begin
        expQ.push_back(makeObs(progWords[i], 1'b0, 1'b1, 1'b0, PB'(i)));
        expQ.push_back(makeObs('0, 1'b0, 1'b1, 1'b1, PB'(i)));
        expQ.push_back(makeObs('0, 1'b0, 1'b0, 1'b0, PB'(i)));
        lastPc = PB'(i);
        return;
      end
      repeat (progHolds[i]) expQ.push_back(makeObs(progWords[i], 1'b0, 1'b1, 1'b0, PB'(i)));
      prev = progWords[i];
    end
    lastPc = PB'(eff - 1);
    expQ.push_back(makeObs('0, 1'b0, 1'b1, 1'b1, lastPc));
    expQ.push_back(makeObs('0, 1'b0, 1'b0, 1'b0, lastPc));
  endtask

  // Compares up to count queued cycles; the queue length bounds every wait.
  task automatic drain(input int count, input bit keepStart);
    obs_t expected;
    for (int i = 0; i < count && expQ.size() > 0; i++) begin
      @(negedge clk);
      expected = expQ.pop_front();
      checkOutput($sformatf("%s[%0d]", curLabel, i), sampleDut(), expected);
      if (!keepStart) begin
        start = 1'b0;
        abort = 1'b0;
      end
    end
  endtask

  task automatic runAndCheck(input string label, input int len);
    curLabel = label;
    prog_len = (PB + 1)'(len);
    applyStimulus(1'b1, 1'b0);
    pushRun(len);
    drain(expQ.size(), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int firstRun;
    fullWords = '{20'h47000, 20'h53000, 20'h72001, 20'hD81E0, 20'hCC160, 20'hB80F0};
    fullHolds = '{3, 3, 3, 3, 3, 4};
    vecs[0] = '{20'h47000, 3, "alu"};
    vecs[1] = '{20'h7FFFF, 3, "alu_max"};
    vecs[2] = '{20'hB80F0, 4, "load"};
    vecs[3] = '{20'h80000, 4, "load_min"};
    vecs[4] = '{20'hD81E0, 3, "store"};
    vecs[5] = '{20'h00000, 0, "halt"};

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0; lastPc = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset[%0d]", i), sampleDut(), makeObs('0, 1'b1, 1'b0, 1'b0, '0));
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", sampleDut(), makeObs('0, 1'b0, 1'b0, 1'b0, '0));

    useFullProgram();
    loadProgram(6);
    runAndCheck("full", 6);

    runAndCheck("zero_len", 0);

    foreach (vecs[v]) begin
      progWords[0] = vecs[v].word;
      progHolds[0] = vecs[v].hold;
      loadProgram(1);
      runAndCheck(vecs[v].label, 1);
    end

    progWords[0] = 20'h47000; progHolds[0] = 3;
    progWords[1] = 20'h00000; progHolds[1] = 0;
    progWords[2] = 20'h53000; progHolds[2] = 3;
    loadProgram(3);
    runAndCheck("early_halt", 3);

    for (int i = 0; i < 32; i++) begin
      progWords[i] = 20'h40000 | IW'(i);
      progHolds[i] = 3;
    end
    loadProgram(32);
    runAndCheck("len_clamp", 40);

    // Abort in the first ISSUE cycle of pc 2 while writes are attempted mid-run.
    useFullProgram();
    loadProgram(6);
    curLabel = "abort";
    prog_len = 7'd6;
    applyStimulus(1'b1, 1'b0);
    pushRun(6);
    drain(1, 1'b0);
    prog_we = 1'b1; prog_addr = 5'd3; prog_data = 20'h00000;
    drain(11, 1'b0);
    abort = 1'b1;
    prog_we = 1'b0;
    expQ.delete();
    lastPc = '0;
    repeat (3) expQ.push_back(makeObs('0, 1'b0, 1'b0, 1'b0, '0));
    drain(3, 1'b0);

    runAndCheck("rerun_after_gated_write", 6);

    // Start held through a whole run restarts from IDLE; abort stops the second run.
    curLabel = "start_held";
    applyStimulus(1'b1, 1'b0);
    pushRun(6);
    firstRun = expQ.size();
    pushRun(6);
    drain(firstRun + 3, 1'b1);
    start = 1'b0;
    abort = 1'b1;
    expQ.delete();
    lastPc = '0;
    repeat (2) expQ.push_back(makeObs('0, 1'b0, 1'b0, 1'b0, '0));
    drain(2, 1'b0);

    curLabel = "start_abort_idle";
    applyStimulus(1'b1, 1'b1);
    pushRun(6);
    drain(expQ.size(), 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cpu_program_sequencer.md
Name: cpu_program_sequencer

Overview:
- Sequencer that owns a small instruction memory and drives the instruction and reset inputs of simple_cpu.
- Software or a bench preloads a program, then pulses start.
- The block resets the CPU, then issues each instruction and holds it stable for an opcode-dependent number of cycles.
- Raises done when the program ends; replaces hand-timed instruction driving in top-level benches.

Parameters:
INSTR_WIDTH, 20, instruction word width (opcode in [INSTR_WIDTH-1:INSTR_WIDTH-2])
PC_BITS, 5, program memory address width (32 words)
ALU_CYCLES, 3, hold cycles for opcode 2'b01 (ADD/SUB)
LOAD_CYCLES, 4, hold cycles for opcode 2'b10 (LOAD_R)
STORE_CYCLES, 3, hold cycles for opcode 2'b11 (STORE_R)
CPU_RST_CYCLES, 2, cycles cpu_rst is held at program start

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
prog_we  in  1  program memory write enable
prog_addr  in  PC_BITS  program write address
prog_data  in  INSTR_WIDTH  program write data
prog_len  in  PC_BITS+1  number of instructions to run
start  in  1  start request, sampled in IDLE only
abort  in  1  abandon the running program
instruction  out  INSTR_WIDTH  instruction to simple_cpu
cpu_rst  out  1  reset to simple_cpu
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at program end
pc  out  PC_BITS  index of the current instruction

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, instruction 0, cpu_rst 1, busy 0, done 0, pc 0, hold counter 0. Memory contents are not reset.
- cpu_rst is 0 in IDLE, FETCH, ISSUE and DONE. It is 1 only in reset and in CPU_RST.
- States and transitions:
  - IDLE:
    - start=1 and prog_len != 0: go to CPU_RST.
    - start=1 and prog_len == 0: go to DONE.
    - Otherwise stay in IDLE.
  - CPU_RST: hold for CPU_RST_CYCLES cycles with cpu_rst=1 and instruction=0, then go to FETCH with pc=0.
  - FETCH: 1 cycle. Synchronous memory read at pc. instruction keeps its previous value.
  - ISSUE:
    - Entry edge: instruction <= mem[pc]; hold count N is decoded from the opcode.
    - Opcode 2'b00 is HALT: go to DONE on the next edge, instruction <= 0, no CPU work.
    - Otherwise stay exactly N cycles with instruction stable.
    - After N cycles: if pc+1 == effective length, go to DONE; else pc <= pc+1 and go to FETCH.
  - DONE: done=1 for 1 cycle, instruction <= 0, then IDLE. pc keeps the last index.
- Effective length is min(prog_len, 2^PC_BITS). There is no pc wrap-around.
- Per-instruction cost is 1 + N cycles.
- Program writes:
  - Accepted only when busy=0; ignored while busy.
  - A write is visible to a FETCH in the next cycle or later.
- start while busy is ignored.
- abort:
  - From any busy state, the next state is IDLE.
  - instruction <= 0, pc <= 0, cpu_rst 0, no done pulse.
  - abort in IDLE is ignored.
  - If start and abort are both high in IDLE, start wins.
- rst mid-program overrides everything and returns all outputs to their reset values.

Decomposition:
- Shared package cpu_pkg holds:
  - OPC_NOP_HALT=2'b00, OPC_ALU=2'b01, OPC_LOAD=2'b10, OPC_STORE=2'b11.
  - The opcode field position.
  - The state encoding (IDLE, CPU_RST, FETCH, ISSUE, DONE).
  - Default cycle-count constants shared with simple_cpu.
- One sub-module, instr_rom_sp: PC_BITS x INSTR_WIDTH memory with one synchronous write port and a synchronous read.
- FSM, hold counter and pc live in the top module.

Test Plan:
- Reset check: hold rst 3 cycles -> instruction=0, cpu_rst=1, busy=0, done=0, pc=0. Release -> cpu_rst=0 in IDLE.
- Full program: load 0x47000, 0x53000, 0x72001, 0xD81E0, 0xCC160, 0xB80F0 at addr 0-5, prog_len=6, pulse start (sampling edge E0):
  - cpu_rst=1 for 2 cycles.
  - Each instruction held 3/3/3/3/3/4 cycles in order.
  - done=1 exactly in the cycle after edge E0+27.
  - With simple_cpu attached: reg0=4, reg1=7, reg3=7, DMEM[17]=7, DMEM[22]=4.
- Early HALT: program 0x47000, 0x00000, 0x53000, prog_len=3 -> only 0x47000 is issued; done follows the HALT fetch; 0x53000 never appears.
- Zero length: prog_len=0, start -> busy=1 for only the DONE cycle, done pulses on the next cycle, cpu_rst stays 0.
- Abort and write gating:
  - Abort during the ISSUE of instruction 2 -> next cycle IDLE, instruction=0, pc=0, no done.
  - prog_we while busy leaves memory unchanged; a rerun shows the original words.
- Start collisions: start held high for the whole run -> program runs once, then restarts from IDLE. start+abort together in IDLE -> run begins.
